// File: rtl/fifo_rd_tx_feeder_pkg.sv
// Shared definitions for the FIFO read-side transmit feeder: FSM encoding and
// helpers that size the ack timer and retry counter from their parameters.
package fifo_rd_tx_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } feeder_state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ACK_TIMEOUT = 16;
  localparam int DEF_MAX_RETRY   = 3;
  localparam int DEF_CNT_WIDTH   = 8;

  // Bits needed to hold the value max_count itself, never less than one.
  function automatic int timer_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

  function automatic int retry_width(input int max_retry);
    if (max_retry < 1) begin
      return 1;
    end
    return $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_tx_feeder_ack_timer.sv
// Loadable down-counter for handshake timeouts. o_expire marks the last counted
// cycle, so a load of N gives exactly N cycles before the owner acts on expiry.
module fifo_rd_tx_feeder_ack_timer #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clear,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expire = (r_count == WIDTH'(1));

endmodule

// File: rtl/fifo_rd_tx_feeder.sv
// Read-domain consumer of the async FIFO: pops one byte, hands it to the UART
// transmitter over a valid/busy handshake with ack timeout and bounded retry.
//
// state        | meaning
// ST_IDLE      | waiting for enable, FIFO data and an idle transmitter
// ST_POP       | rinc high for one cycle, byte already captured in tx_data
// ST_SEND      | tx_valid high for one cycle, ack timer loaded
// ST_WAIT_ACK  | waiting for tx_busy to rise, retry or drop on timer expiry
// ST_WAIT_DONE | transmitter busy with the frame, count it when busy falls
module fifo_rd_tx_feeder
  import fifo_rd_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int MAX_RETRY   = DEF_MAX_RETRY,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_rempty,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_rinc,
  input  logic                  i_tx_busy,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  output logic [CNT_WIDTH-1:0]  o_sent_cnt,
  output logic                  o_timeout_err
);

  localparam int TW = timer_width(ACK_TIMEOUT);
  localparam int RW = retry_width(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_LOAD  = TW'(ACK_TIMEOUT);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  feeder_state_t         r_state;
  logic [RW-1:0]         r_retry;
  logic                  r_rinc;
  logic                  r_tx_valid;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [CNT_WIDTH-1:0]  r_sent_cnt;
  logic                  r_timeout_err;

  logic w_timer_load;
  logic w_timer_clear;
  logic w_timer_expire;

  assign w_timer_load  = (r_state == ST_SEND);
  assign w_timer_clear = (r_state == ST_WAIT_ACK) && i_tx_busy;

  fifo_rd_tx_feeder_ack_timer #(
    .WIDTH (TW)
  ) u_ack_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_timer_load),
    .i_load_val (TIMER_LOAD),
    .i_clear    (w_timer_clear),
    .o_expire   (w_timer_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_retry       <= '0;
      r_rinc        <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= '0;
      r_sent_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rinc     <= 1'b0;
      r_tx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A busy transmitter here is a stale frame; wait it out before popping.
          if (i_enable && !i_rempty && !i_tx_busy) begin
            r_tx_data <= i_rdata;
            r_rinc    <= 1'b1;
            r_state   <= ST_POP;
          end
        end
        ST_POP: begin
          r_retry    <= '0;
          r_tx_valid <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Ack is checked first so a busy rise on the expiry cycle is not retried.
          if (i_tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (w_timer_expire) begin
            if (r_retry < RETRY_LIMIT) begin
              r_retry    <= r_retry + RW'(1);
              r_tx_valid <= 1'b1;
              r_state    <= ST_SEND;
            end else begin
              r_timeout_err <= 1'b1;
              r_state       <= ST_IDLE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (!i_tx_busy) begin
            r_sent_cnt <= r_sent_cnt + CNT_WIDTH'(1);
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rinc        = r_rinc;
  assign o_tx_valid    = r_tx_valid;
  assign o_tx_data     = r_tx_data;
  assign o_sent_cnt    = r_sent_cnt;
  assign o_timeout_err = r_timeout_err;

endmodule
